// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency/phase measurement chain:
// generator FSM states and the generator's default sizing.
package freq_meter_pkg;

   localparam int CNT_W_DEFAULT = 32;
   localparam int HALF_DEFAULT  = 50000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } gen_state_t;

endpackage

// File: rtl/dual_sig_gen_wrap_counter.sv
// Loadable modulo-period counter. Clear has priority over load, and load
// has priority over counting. The compare output flags cnt < cmp_val.
module wrap_counter #(
   parameter int W = 33
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic         run,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] period,
   input  logic [W-1:0] cmp_val,
   output logic         below,
   output logic         at_last,
   output logic         at_zero
);

   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO = {W{1'b0}};

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_nx_s;

   // Next count: clear, reload, wrap at period-1, or hold.
   always_comb begin
      cnt_nx_s = cnt_r;
      if (clr) begin
         cnt_nx_s = ZERO;
      end else if (load) begin
         cnt_nx_s = load_val;
      end else if (run) begin
         if (at_last) begin
            cnt_nx_s = ZERO;
         end else begin
            cnt_nx_s = cnt_r + ONE;
         end
      end else begin
         cnt_nx_s = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= ZERO;
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end

   assign below   = (cnt_r < cmp_val);
   assign at_last = (cnt_r == (period - ONE));
   assign at_zero = (cnt_r == ZERO);

endmodule

// File: rtl/dual_sig_gen.sv
// Two-channel square-wave source. Channel 1 is channel 0 delayed by a
// programmed number of cycles. Settings pass through a one-entry shadow
// and are applied only at period boundaries (or at once while idle).
module dual_sig_gen
   import freq_meter_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEFAULT,
   parameter int DEF_HALF = HALF_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_half_period,
   input  logic [CNT_W-1:0] cfg_phase_delay,
   output logic             sig_out0,
   output logic             sig_out1,
   output logic             period_tick,
   output logic             busy,
   output logic             cfg_err
);

   localparam int PW = CNT_W + 1;
   localparam logic [CNT_W-1:0] H_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] H_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);
   localparam logic [PW-1:0]    P_ZERO   = {PW{1'b0}};
   localparam logic [PW-1:0]    P_ONE    = {{(PW-1){1'b0}}, 1'b1};

   // A zero half-period would give an empty period; the shortest legal one is 1.
   function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] h);
      if (h == H_ZERO) begin
         return H_ONE;
      end else begin
         return h;
      end
   endfunction

   // The delay must stay inside one period of the clamped half-period.
   function automatic logic [CNT_W-1:0] clamp_delay(input logic [CNT_W-1:0] d,
                                                     input logic [CNT_W-1:0] hc);
      logic [PW-1:0] p;
      logic [PW-1:0] lim;
      p   = {hc, 1'b0};
      lim = p - P_ONE;
      if ({1'b0, d} >= p) begin
         return lim[CNT_W-1:0];
      end else begin
         return d;
      end
   endfunction

   gen_state_t       state_r;
   gen_state_t       state_nx_s;
   logic [CNT_W-1:0] half_r;
   logic [CNT_W-1:0] delay_r;
   logic [CNT_W-1:0] sh_half_r;
   logic [CNT_W-1:0] sh_delay_r;
   logic             sh_full_r;
   logic             err_r;
   logic             sig0_r;
   logic             sig1_r;
   logic             tick_r;
   logic             busy_r;

   logic             capture_s;
   logic             apply_s;
   logic             clamp_hit_s;
   logic [CNT_W-1:0] cap_half_s;
   logic [CNT_W-1:0] cap_delay_s;
   logic [CNT_W-1:0] half_nx_s;
   logic [CNT_W-1:0] delay_nx_s;
   logic [PW-1:0]    period_s;
   logic [PW-1:0]    period_nx_s;
   logic [PW-1:0]    start1_s;
   logic [PW-1:0]    half_cmp_s;
   logic             clr_s;
   logic             load_s;
   logic             run_s;
   logic             out_en_s;
   logic             below0_s;
   logic             last0_s;
   logic             zero0_s;
   logic             below1_s;
   logic             ch1_last_unused_s;
   logic             ch1_zero_unused_s;

   assign cfg_ready   = !sh_full_r;
   assign capture_s   = cfg_valid && !sh_full_r;
   assign period_s    = {half_r, 1'b0};
   assign half_cmp_s  = {1'b0, half_r};
   assign sig_out0    = sig0_r;
   assign sig_out1    = sig1_r;
   assign period_tick = tick_r;
   assign busy        = busy_r;
   assign cfg_err     = err_r;

   // Clamp the offered config word and flag whether anything was altered.
   always_comb begin
      cap_half_s  = clamp_half(cfg_half_period);
      cap_delay_s = clamp_delay(cfg_phase_delay, cap_half_s);
      if ((cfg_half_period == H_ZERO) || (cap_delay_s != cfg_phase_delay)) begin
         clamp_hit_s = 1'b1;
      end else begin
         clamp_hit_s = 1'b0;
      end
   end

   // Apply point and the settings that govern the next period.
   always_comb begin
      apply_s = 1'b0;
      if (sh_full_r && ((state_r == IDLE) || last0_s)) begin
         apply_s = 1'b1;
      end else begin
         apply_s = 1'b0;
      end
      if (apply_s) begin
         half_nx_s  = sh_half_r;
         delay_nx_s = sh_delay_r;
      end else begin
         half_nx_s  = half_r;
         delay_nx_s = delay_r;
      end
      period_nx_s = {half_nx_s, 1'b0};
      if (delay_nx_s == H_ZERO) begin
         start1_s = P_ZERO;
      end else begin
         start1_s = period_nx_s - {1'b0, delay_nx_s};
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state: an idle apply delays the start by one cycle.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable && !apply_s) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (!enable) begin
               state_nx_s = DRAIN;
            end else begin
               state_nx_s = RUN;
            end
         end
         DRAIN: begin
            if (enable) begin
               state_nx_s = RUN;
            end else if (last0_s) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DRAIN;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // FSM outputs: counter control and output gating.
   always_comb begin
      run_s    = 1'b0;
      clr_s    = 1'b0;
      load_s   = 1'b0;
      out_en_s = 1'b0;
      case (state_r)
         IDLE: begin
            clr_s  = (state_nx_s == IDLE);
            load_s = (state_nx_s == RUN);
         end
         RUN, DRAIN: begin
            run_s    = 1'b1;
            clr_s    = (state_nx_s == IDLE);
            load_s   = last0_s && (state_nx_s != IDLE);
            out_en_s = (state_nx_s != IDLE);
         end
         default: begin
            clr_s = 1'b1;
         end
      endcase
   end

   // Shadow capture and transfer into the active settings.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         half_r     <= HALF_RST;
         delay_r    <= H_ZERO;
         sh_half_r  <= H_ZERO;
         sh_delay_r <= H_ZERO;
         sh_full_r  <= 1'b0;
      end else if (capture_s) begin
         sh_half_r  <= cap_half_s;
         sh_delay_r <= cap_delay_s;
         sh_full_r  <= 1'b1;
      end else if (apply_s) begin
         half_r     <= sh_half_r;
         delay_r    <= sh_delay_r;
         sh_full_r  <= 1'b0;
      end else begin
         sh_full_r  <= sh_full_r;
      end
   end

   // Sticky clamp flag.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (capture_s && clamp_hit_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Registered outputs; both channels are forced low on the way to IDLE.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sig0_r <= 1'b0;
         sig1_r <= 1'b0;
         tick_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         if (out_en_s) begin
            sig0_r <= below0_s;
            sig1_r <= below1_s;
         end else begin
            sig0_r <= 1'b0;
            sig1_r <= 1'b0;
         end
         tick_r <= run_s && zero0_s;
         busy_r <= (state_nx_s != IDLE);
      end
   end

   wrap_counter #(.W(PW)) u_cnt0 (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .clr      (clr_s),
      .load     (load_s),
      .run      (run_s),
      .load_val (P_ZERO),
      .period   (period_s),
      .cmp_val  (half_cmp_s),
      .below    (below0_s),
      .at_last  (last0_s),
      .at_zero  (zero0_s)
   );

   wrap_counter #(.W(PW)) u_cnt1 (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .clr      (clr_s),
      .load     (load_s),
      .run      (run_s),
      .load_val (start1_s),
      .period   (period_s),
      .cmp_val  (half_cmp_s),
      .below    (below1_s),
      .at_last  (ch1_last_unused_s),
      .at_zero  (ch1_zero_unused_s)
   );

endmodule

// File: tb/tb_dual_sig_gen.sv
// Randomized bench for dual_sig_gen against a period-position reference model.
module tb_dual_sig_gen;

   localparam int TW   = 16;
   localparam int TDEF = 4;

   logic          sys_clk;
   logic          rst_n;
   logic          enable;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [TW-1:0] cfg_half_period;
   logic [TW-1:0] cfg_phase_delay;
   logic          sig_out0;
   logic          sig_out1;
   logic          period_tick;
   logic          busy;
   logic          cfg_err;

   int total;
   int bad;

   // reference model: position inside the current period plus settings
   bit m_run;
   bit m_drain;
   bit m_err;
   int m_pos;
   int m_half;
   int m_delay;
   int q_half[$];
   int q_delay[$];
   bit e_out0;
   bit e_out1;
   bit e_tick;
   bit acc_last;

   dual_sig_gen #(.CNT_W(TW), .DEF_HALF(TDEF)) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_half_period (cfg_half_period),
      .cfg_phase_delay (cfg_phase_delay),
      .sig_out0        (sig_out0),
      .sig_out1        (sig_out1),
      .period_tick     (period_tick),
      .busy            (busy),
      .cfg_err         (cfg_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_drain = 0; m_err = 0; m_pos = 0;
      m_half = TDEF; m_delay = 0;
      q_half.delete(); q_delay.delete();
   endtask

   // One clock edge of the reference: outputs seen after the edge reflect
   // the period position held before it.
   task automatic model_step();
      int  p, h, d;
      bit  wrap, apply, cap, stop;
      p     = 2 * m_half;
      wrap  = m_run && (m_pos == p - 1);
      apply = (q_half.size() != 0) && (!m_run || wrap);
      cap   = cfg_valid && (q_half.size() == 0);
      stop  = wrap && m_drain && !enable;
      e_out0 = m_run && !stop && (m_pos < m_half);
      e_out1 = m_run && !stop && (((m_pos + p - m_delay) % p) < m_half);
      e_tick = m_run && (m_pos == 0);
      acc_last = cap;
      if (!m_run) begin
         if (enable && !apply) begin
            m_run = 1; m_drain = 0; m_pos = 0;
         end
      end else if (stop) begin
         m_run = 0; m_drain = 0; m_pos = 0;
      end else begin
         m_pos   = wrap ? 0 : m_pos + 1;
         m_drain = !enable;
      end
      if (apply) begin
         m_half  = q_half.pop_front();
         m_delay = q_delay.pop_front();
      end
      if (cap) begin
         h = int'(cfg_half_period);
         d = int'(cfg_phase_delay);
         if (h == 0) begin h = 1; m_err = 1; end
         if (d >= 2 * h) begin d = 2 * h - 1; m_err = 1; end
         q_half.push_back(h);
         q_delay.push_back(d);
      end
   endtask

   task automatic cycle();
      @(posedge sys_clk);
      model_step();
      #1;
      check_val("sig_out0", sig_out0, e_out0);
      check_val("sig_out1", sig_out1, e_out1);
      check_val("period_tick", period_tick, e_tick);
      check_val("busy", busy, m_run);
      check_val("cfg_ready", cfg_ready, q_half.size() == 0);
      check_val("cfg_err", cfg_err, m_err);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_cfg(input int h, input int d, input bit keep);
      bit done;
      done = 0;
      cfg_valid       = 1'b1;
      cfg_half_period = TW'(h);
      cfg_phase_delay = TW'(d);
      for (int i = 0; i < 200 && !done; i++) begin
         cycle();
         done = acc_last;
      end
      check_val("cfg_accepted", done, 1'b1);
      if (!keep) cfg_valid = 1'b0;
   endtask

   task automatic wait_pos(input int target);
      bit ok;
      ok = m_run && (m_pos == target);
      for (int i = 0; i < 200 && !ok; i++) begin
         cycle();
         ok = m_run && (m_pos == target);
      end
      check_val("wait_pos", ok, 1'b1);
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
      cfg_half_period = '0; cfg_phase_delay = '0;
      model_reset();
      #12;
      check_val("rst_sig_out0", sig_out0, 1'b0);
      check_val("rst_sig_out1", sig_out1, 1'b0);
      check_val("rst_tick", period_tick, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_cfg_err", cfg_err, 1'b0);
      check_val("rst_cfg_ready", cfg_ready, 1'b1);
      #15 rst_n = 1'b1;

      // basic run: half 4, delay 2
      send_cfg(4, 2, 0);
      cycle();
      enable = 1'b1;
      run_cycles(40);

      // zero delay
      send_cfg(3, 0, 0);
      run_cycles(30);

      // mid-run reconfiguration at position 3 of an 8-cycle period
      send_cfg(4, 2, 0);
      run_cycles(12);
      wait_pos(3);
      send_cfg(2, 1, 0);
      run_cycles(20);

      // clamping
      send_cfg(0, 9, 0);
      run_cycles(10);
      check_val("clamp_err", cfg_err, 1'b1);

      // backpressure: two back-to-back words
      send_cfg(3, 1, 1);
      send_cfg(5, 4, 0);
      run_cycles(40);

      // stop mid-period
      wait_pos(2);
      enable = 1'b0;
      run_cycles(30);
      check_val("stopped_busy", busy, 1'b0);

      // enable falling on the wrap cycle
      enable = 1'b1;
      run_cycles(5);
      wait_pos(2 * m_half - 1);
      enable = 1'b0;
      run_cycles(30);

      // randomized traffic
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) enable = ~enable;
         if (!cfg_valid && $urandom_range(0, 9) == 0) begin
            cfg_valid       = 1'b1;
            cfg_half_period = TW'($urandom_range(0, 6));
            cfg_phase_delay = TW'($urandom_range(0, 15));
         end
         cycle();
         if (acc_last) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_half_period = TW'($urandom_range(0, 6));
            cfg_phase_delay = TW'($urandom_range(0, 15));
         end
      end
      cfg_valid = 1'b0;

      // asynchronous reset mid-pulse with a pending shadow
      enable = 1'b1;
      send_cfg(4, 1, 0);
      run_cycles(20);
      wait_pos(0);
      send_cfg(6, 3, 0);
      check_val("pre_rst_out0", sig_out0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_sig_out0", sig_out0, 1'b0);
      check_val("arst_sig_out1", sig_out1, 1'b0);
      check_val("arst_tick", period_tick, 1'b0);
      check_val("arst_busy", busy, 1'b0);
      check_val("arst_cfg_ready", cfg_ready, 1'b1);
      check_val("arst_cfg_err", cfg_err, 1'b0);
      model_reset();
      #3 rst_n = 1'b1;
      run_cycles(25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
